mux_arbiter8: RTL

MUX_ARBITER8 -- requirements
Module: mux_arbiter8

---
 rtl/mux_arbiter8.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mux_arbiter8.sv
// mux_arbiter8 - eight-way round-robin arbiter with an 8:1 data mux.
//
// A granted requester keeps the grant until one of three things happens.
// It may complete MAX_BURST transfers, it may drop its request, or reset
// may be asserted. Other requesters cannot take the grant away. When the
// grant is released, priority rotates to the index after the released
// requester.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   req[7:0]   request vector, bit i = requester i has a word
//   d0..d7     data word of each requester
//   out_ready  consumer accepts out_data this cycle
//   out_valid  out_data is valid (granted requester still requesting)
//   out_data   data word of the requester selected by sel
//   sel[2:0]   registered index of the granted requester
//   gnt[7:0]   registered one-hot grant, zero when nothing is granted
//   ack[7:0]   one-hot transfer acknowledge, asserted in the transfer cycle
//   busy       high while a grant is held
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no grant; arbitrate req starting at ptr, grant on next edge
// GRANT | requester sel owns the output; count transfers up to MAX_BURST

module mux_arbiter8 #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] d0,
    input  logic [7:0] d1,
    input  logic [7:0] d2,
    input  logic [7:0] d3,
    input  logic [7:0] d4,
    input  logic [7:0] d5,
    input  logic [7:0] d6,
    input  logic [7:0] d7,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic [7:0] ack,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST);

    state_t     state;
    logic [2:0] ptr;
    logic [3:0] burst_cnt;
    logic [3:0] burst_next;
    logic [2:0] pick;
    logic [2:0] idx;
    logic       found;
    logic       xfer;

    // Rotating priority search. The index arithmetic is 3 bits wide, so
    // the search wraps from 7 back to 0 without any extra logic.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = ptr;
        for (int i = 0; i < 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign out_valid  = (state == GRANT) && req[sel];
    assign xfer       = out_valid && out_ready;
    // gnt is zero outside GRANT, so ack is always a subset of gnt.
    assign ack        = xfer ? gnt : 8'h00;
    assign burst_next = burst_cnt + 4'd1;

    always_comb begin
        out_data = d0;
        case (sel)
            3'd0: out_data = d0;
            3'd1: out_data = d1;
            3'd2: out_data = d2;
            3'd3: out_data = d3;
            3'd4: out_data = d4;
            3'd5: out_data = d5;
            3'd6: out_data = d6;
            3'd7: out_data = d7;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            sel       <= 3'd0;
            gnt       <= 8'h00;
            burst_cnt <= 4'd0;
            busy      <= 1'b0;
        end else if (state == IDLE) begin
            if (found) begin
                state     <= GRANT;
                busy      <= 1'b1;
                sel       <= pick;
                gnt       <= 8'h01 << pick;
                burst_cnt <= 4'd0;
            end
        end else begin
            if (xfer && (burst_next != BURST_LAST)) begin
                burst_cnt <= burst_next;
            end else if (xfer || !req[sel]) begin
                // This is the last word of the burst, or the requester has
                // gone away. Release the grant and rotate priority past it.
                state     <= IDLE;
                busy      <= 1'b0;
                gnt       <= 8'h00;
                ptr       <= sel + 3'd1;
                burst_cnt <= 4'd0;
            end
        end
    end

endmodule
